sar_search: RTL and testbench

- Successive-approximation search controller; the initiator side of the magnitude-comparator interface.
- Drives a registered `guess` into an external combinational comparator that compares `guess` (x) against a hidden `target` (y).
- Reads back eq/lt/gt and resolves `target` MSB-first in at most WIDTH compare cycles.
- Used to recover an unknown value, e.g. a DIP-switch value or a threshold, through a comparator-only path.

---
 rtl/sar_search.sv | 111 +++++++++++
 tb/tb_sar_search.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// Successive-approximation search controller: drives a registered guess into an
// external comparator and resolves the hidden target MSB-first. Optional macro: SAR_EARLY_EXIT_EN.
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  input  logic             cmp_gt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {IDLE = 1'b0, TRY = 1'b1} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] probe;
  logic [WIDTH-1:0] kept;
  logic             onehot;
  logic             last;

  function automatic logic flags_onehot(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
  endfunction

  // Decision for the bit under test and end-of-search detection.
  always_comb begin
    probe  = ONE << idx;
    onehot = flags_onehot({cmp_eq, cmp_lt, cmp_gt});
    if (cmp_gt) begin
      kept = guess & ~probe;
    end else begin
      kept = guess;
    end
`ifdef SAR_EARLY_EXIT_EN
    if ((idx == '0) || (onehot && cmp_eq)) begin
      last = 1'b1;
    end else begin
      last = 1'b0;
    end
`else
    if (idx == '0) begin
      last = 1'b1;
    end else begin
      last = 1'b0;
    end
`endif
  end

  // Search FSM; every output is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      guess  <= '0;
      result <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            guess <= MSB;
            idx   <= IW'(WIDTH - 1);
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= TRY;
          end else begin
            state <= IDLE;
          end
        end
        TRY: begin
          // Malformed flags are recorded but the search still follows cmp_gt.
          if (!onehot) begin
            err <= 1'b1;
          end else begin
            err <= err;
          end
          if (last) begin
            guess  <= kept;
            result <= kept;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            guess <= kept | (probe >> 1);
            idx   <= idx - IW'(1);
            state <= TRY;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Directed, table-driven bench for sar_search (WIDTH=4) with a behavioural comparator.
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cmp_eq, cmp_lt, cmp_gt;
  logic [3:0] guess, result;
  logic       busy, done, err;

  logic [3:0] tgt;
  logic       force_eq;
  logic       force_none;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  assign cmp_eq = force_none ? 1'b0 : ((guess == tgt) | force_eq);
  assign cmp_lt = force_none ? 1'b0 : (guess < tgt);
  assign cmp_gt = force_none ? 1'b0 : (guess > tgt);

  sar_search #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_gt(cmp_gt),
    .guess(guess), .busy(busy), .done(done), .result(result), .err(err)
  );

  typedef struct {
    logic [3:0]       target;
    logic [3:0][3:0]  seq;      // {g1,g2,g3,g4}
    int               n_early;  // compares when early exit is built in
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a search, checks each presented guess, then the done pulse and result.
  task automatic run_search(input vec_t v);
    int n;
    n = EARLY ? v.n_early : 4;
    tgt = v.target;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("guess t=%0h k=%0d", v.target, k), 32'(guess), 32'(v.seq[3-k]));
      chk($sformatf("busy t=%0h k=%0d", v.target, k), 32'(busy), 32'd1);
      chk($sformatf("nodone t=%0h k=%0d", v.target, k), 32'(done), 32'd0);
      @(negedge clk);
    end
    chk($sformatf("done t=%0h", v.target), 32'(done), 32'd1);
    chk($sformatf("idle t=%0h", v.target), 32'(busy), 32'd0);
    chk($sformatf("result t=%0h", v.target), 32'(result), 32'(v.target));
    chk($sformatf("err t=%0h", v.target), 32'(err), 32'd0);
    @(negedge clk);
    chk($sformatf("pulse t=%0h", v.target), 32'(done), 32'd0);
    chk($sformatf("hold t=%0h", v.target), 32'(result), 32'(v.target));
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int n6;

    vecs[0] = '{4'hB, 16'h8CAB, 4};
    vecs[1] = '{4'h0, 16'h8421, 4};
    vecs[2] = '{4'hF, 16'h8CEF, 4};
    vecs[3] = '{4'h6, 16'h8467, 3};
    vecs[4] = '{4'h9, 16'h8CA9, 4};
    vecs[5] = '{4'h8, 16'h8CA9, 1};
    vecs[6] = '{4'h5, 16'h8465, 4};
    vecs[7] = '{4'hC, 16'h8CED, 2};

    rst = 1'b1; start = 1'b0; tgt = 4'h0; force_eq = 1'b0; force_none = 1'b0;
    #12;
    chk("rst guess", 32'(guess), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Flags are ignored while idle, even when all are low.
    force_none = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle flags err", 32'(err), 32'd0);
    chk("idle busy", 32'(busy), 32'd0);
    force_none = 1'b0;

    foreach (vecs[i]) run_search(vecs[i]);

    // start held through the done edge: exactly one search.
    n6 = EARLY ? 3 : 4;
    tgt = 4'h6;
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge clk) start = 1'b1;
    for (int c = 0; c < n6; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    @(negedge clk) start = 1'b0;
    if (done) done_cnt++;
    chk("held busy_after_done", 32'(busy), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    chk("held busy cycles", 32'(busy_cnt), 32'(n6));
    chk("held done pulses", 32'(done_cnt), 32'd1);
    chk("held result", 32'(result), 32'h6);

    // Asynchronous reset after the 2nd compare aborts the search.
    tgt = 4'hB;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst done", 32'(done), 32'd0);
    chk("arst guess", 32'(guess), 32'd0);
    chk("arst result", 32'(result), 32'd0);
    @(negedge clk) rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("arst no done", 32'(done_cnt), 32'd0);
    run_search(vecs[4]);

    // eq and gt both high on the 2nd compare: sticky err, decision follows gt.
    tgt = 4'hB;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("err pre", 32'(err), 32'd0);
    @(negedge clk) force_eq = 1'b1;
    chk("err guess2", 32'(guess), 32'hC);
    @(negedge clk) force_eq = 1'b0;
    chk("err set", 32'(err), 32'd1);
    @(negedge clk);
    chk("err sticky", 32'(err), 32'd1);
    @(negedge clk);
    chk("err done", 32'(done), 32'd1);
    chk("err at done", 32'(err), 32'd1);
    chk("err result", 32'(result), 32'hB);
    @(negedge clk);
    chk("err after done", 32'(err), 32'd1);
    run_search(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
